ps2_scancode_rx: RTL and testbench

PS/2 keyboard receiver for the production-test core. It sits between the raw `clkps2`/`dataps2` pins and the mode-switch logic that toggles composite/VGA output. It samples the asynchronous PS/2 lines in the 7 MHz video clock domain, deframes 11-bit device-to-host frames and checks parity. It folds E0/F0 prefixes into flags and presents each completed scancode with a one-cycle strobe.

---
 rtl/ps2_scancode_rx_if.sv | 19 +
 rtl/ps2_scancode_rx.sv | 136 +++++++++++++
 tb/tb_ps2_scancode_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: PS/2 pin pair and decoded scancode outputs
interface ps2_scancode_rx_if;
  logic       clkps2;
  logic       dataps2;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       kb_interrupt;
  logic       frame_err;
  logic       busy;
  modport master (
    output clkps2, dataps2,
    input  scancode, extended, released, kb_interrupt, frame_err, busy
  );
  modport slave (
    input  clkps2, dataps2,
    output scancode, extended, released, kb_interrupt, frame_err, busy
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard deframer with E0/F0 prefix folding; define PS2_TIMEOUT_EN for the inter-edge watchdog
module ps2_scancode_rx #(
  parameter int CLKFREQ    = 7000,
  parameter int FILTER     = 4,
  parameter int TIMEOUT_US = 150
) (
  input logic               clk,
  input logic               rst_n,
  ps2_scancode_rx_if.slave  bus
);
  localparam int FW     = $clog2(FILTER + 1);
  localparam int TO_CYC = CLKFREQ * TIMEOUT_US / 1000;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          tick_q;
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          ext_pend_q, rel_pend_q;
  logic [7:0]    scancode_q;
  logic          extended_q, released_q, kb_int_q, frame_err_q;
  logic          timeout;
  logic          dat;
  assign dat = dat_sync_q[1];
  // two-flop synchronizers for both asynchronous pins, idling high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.clkps2};
      dat_sync_q <= {dat_sync_q[0], bus.dataps2};
    end
  // filtered clock follows the pin only after FILTER equal samples; tick marks its falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (clk_sync_q[1] == filt_q)
        flt_cnt_q <= '0;
      else if (flt_cnt_q == FW'(FILTER - 1)) begin
        filt_q    <= clk_sync_q[1];
        flt_cnt_q <= '0;
        tick_q    <= filt_q;
      end else
        flt_cnt_q <= flt_cnt_q + 1'b1;
    end
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt_q;
  // saturating gap counter between PS/2 clock edges while a frame is open
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      to_cnt_q <= '0;
    else
      to_cnt_q <= (tick_q || state_q == IDLE) ? '0 :
                  (to_cnt_q == TW'(TO_CYC)) ? to_cnt_q : to_cnt_q + 1'b1;
  assign timeout = state_q != IDLE && !tick_q && to_cnt_q == TW'(TO_CYC);
`else
  // no watchdog in this build: a partial frame waits for further edges forever
  assign timeout = TO_CYC < 0;
`endif
  // frame FSM with prefix folding and registered result/strobe outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      scancode_q  <= '0;
      extended_q  <= 1'b0;
      released_q  <= 1'b0;
      kb_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      kb_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (timeout) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_pend_q  <= 1'b0;
        rel_pend_q  <= 1'b0;
      end else if (tick_q) begin
        case (state_q)
          IDLE: if (!dat) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (dat && (^{shift_q, par_q})) begin
              if (shift_q == 8'hE0)
                ext_pend_q <= 1'b1;
              else if (shift_q == 8'hF0)
                rel_pend_q <= 1'b1;
              else begin
                scancode_q <= shift_q;
                extended_q <= ext_pend_q;
                released_q <= rel_pend_q;
                kb_int_q   <= 1'b1;
                ext_pend_q <= 1'b0;
                rel_pend_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              rel_pend_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  assign bus.scancode     = scancode_q;
  assign bus.extended     = extended_q;
  assign bus.released     = released_q;
  assign bus.kb_interrupt = kb_int_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: scoreboard bench driving PS/2 frames and checking decoded events
module tb_ps2_scancode_rx;
  localparam int FILTER = 4;
  localparam int TO_CYC = 7000 * 150 / 1000;
  localparam int H      = 15;
  typedef struct {
    bit         err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t m_e;
  int errors = 0;
  int checks = 0;
  bit m_ext = 1'b0;
  bit m_rel = 1'b0;
  logic [7:0] p_code = 8'h00;
  logic p_ext = 1'b0;
  logic p_rel = 1'b0;
  always #5 clk = ~clk;
  ps2_scancode_rx_if bus();
  ps2_scancode_rx #(.CLKFREQ(7000), .FILTER(FILTER), .TIMEOUT_US(150)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: what a keyboard host should report for one received frame
  function automatic void model(input logic [7:0] b, input bit good);
    if (!good) begin
      q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      q.push_back('{1'b0, b, m_ext, m_rel});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endfunction
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    bus.dataps2 = b;
    if (glitch) begin
      repeat (5) @(negedge clk);
      bus.clkps2 = 1'b0;
      repeat (FILTER - 1) @(negedge clk);
      bus.clkps2 = 1'b1;
      repeat (H - 5 - (FILTER - 1)) @(negedge clk);
    end else repeat (H) @(negedge clk);
    bus.clkps2 = 1'b0;
    repeat (H) @(negedge clk);
    bus.clkps2 = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    model(b, !bad_par && stop);
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch);
    repeat (20) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_scancode"}, bus.scancode, 8'h00);
    check({tag, "_extended"}, bus.extended, 1'b0);
    check({tag, "_released"}, bus.released, 1'b0);
    check({tag, "_kb_int"}, bus.kb_interrupt, 1'b0);
    check({tag, "_frame_err"}, bus.frame_err, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask
  // monitor: every strobe pops one expectation; results must hold between strobes
  always @(negedge clk) begin
    if (!rst_n) begin
      p_code = bus.scancode;
      p_ext  = bus.extended;
      p_rel  = bus.released;
    end else begin
      if (bus.kb_interrupt || bus.frame_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: kb=%0b err=%0b expected no strobe at %0t",
                   bus.kb_interrupt, bus.frame_err, $time);
        end else begin
          m_e = q.pop_front();
          check("strobe_is_err", bus.frame_err, m_e.err);
          check("strobe_is_kb", bus.kb_interrupt, !m_e.err);
          if (!m_e.err) begin
            check("scancode", bus.scancode, m_e.code);
            check("extended", bus.extended, m_e.ext);
            check("released", bus.released, m_e.rel);
          end
        end
      end
      if (!bus.kb_interrupt)
        check("hold", {bus.scancode, bus.extended, bus.released}, {p_code, p_ext, p_rel});
      p_code = bus.scancode;
      p_ext  = bus.extended;
      p_rel  = bus.released;
    end
  end
  initial begin
    int n;
    logic [7:0] b;
    bus.clkps2  = 1'b1;
    bus.dataps2 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h74, 0, 1, 0);
    send_frame(8'h29, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    check("sc_after_parity_err", bus.scancode, 8'h1C);
    send_frame(8'h1C, 0, 0, 0);
    check("sc_after_stop_err", bus.scancode, 8'h1C);
    send_frame(8'h5A, 0, 1, 1);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    // partial frame: start plus three data bits, then the clock stops
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(i[0], 0);
    check("busy_partial", bus.busy, 1'b1);
`ifdef PS2_TIMEOUT_EN
    model(8'h00, 0);
    n = H;
    while (!bus.frame_err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_seen", bus.frame_err, 1'b1);
    check("timeout_latency_ok", (n >= TO_CYC && n <= TO_CYC + FILTER + 8), 1);
    @(negedge clk);
    check("busy_after_timeout", bus.busy, 1'b0);
    repeat (2000 - n) @(negedge clk);
`else
    repeat (2000) @(negedge clk);
    check("busy_no_timeout", bus.busy, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif
    send_frame(8'h29, 0, 1, 0);
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'h74, 0, 1, 0);
    // reset in the middle of a frame after five data bits
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    m_ext = 1'b0;
    m_rel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      b = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? 8'hE0 : 8'hF0) : 8'($urandom);
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0);
    end
    repeat (50) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
